// File: rtl/fa_pkg.sv
// Shared constants for the registered full adder and its one-bit cell.
package fa_pkg;

  localparam int FA_DEFAULT_WIDTH = 1;
  localparam int FA_MAX_WIDTH     = 64;

endpackage : fa_pkg

// File: rtl/fa_cell.sv
// One-bit combinational full adder; the leaf of the ripple chain in full_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin one cycle later.
// Define FA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module full_adder
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef FA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH out of range 1..64");
  end

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .co  (c[i+1])
    );
  end

  // No enable and no handshake: a new operand set is captured on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[WIDTH];
    end
  end

`ifdef FA_OVERFLOW_EN
  // Carry into and out of the sign bit disagree exactly on signed overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule : full_adder

// File: tb/tb_full_adder.sv
// Directed bench for full_adder: a WIDTH=1 and a WIDTH=8 instance sharing clk/rst.
// Overflow checks are compiled in when FA_OVERFLOW_EN is defined.
module tb_full_adder;

  localparam int SW = 10;  // {ovf, cout, sum[7:0]} for the 8-bit scoreboard

  logic       clk;
  logic       rst;
  logic       a1, b1, cin1;
  logic       sum1, cout1;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] sum8;
  logic       cout8;
`ifdef FA_OVERFLOW_EN
  logic       ovf1, ovf8;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [SW-1:0] exp_q[$];

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .sum  (sum1),
    .cout (cout1)
`ifdef FA_OVERFLOW_EN
    ,
    .ovf  (ovf1)
`endif
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .sum  (sum8),
    .cout (cout8)
`ifdef FA_OVERFLOW_EN
    ,
    .ovf  (ovf8)
`endif
  );

  // Clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive1(input logic [2:0] abc);
    {a1, b1, cin1} = abc;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8   = a;
    b8   = b;
    cin8 = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for the 8-bit instance: exact 9-bit add plus signed-overflow rule.
  function automatic logic [SW-1:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] full;
    logic       v;
    full = {1'b0, a} + {1'b0, b} + {8'd0, c};
    v    = (a[7] == b[7]) && (full[7] != a[7]);
    return {v, full};
  endfunction

  task automatic chk8(input string tag);
    logic [SW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, {8'd0, sum8}, {8'd0, e[7:0]});
      chk({tag, "_cout"}, {15'd0, cout8}, {15'd0, e[8]});
`ifdef FA_OVERFLOW_EN
      chk({tag, "_ovf"}, {15'd0, ovf8}, {15'd0, e[9]});
`endif
    end
  endtask

  logic [1:0] tt[8];

  initial begin
    logic [7:0] ra, rb;
    logic       rc;

    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset held with nonzero inputs and a running clock
    rst = 1'b1;
    drive1(3'b111);
    drive8(8'hFF, 8'hFF, 1'b1);
    #2;
    chk("rst_sum1", {15'd0, sum1}, 16'd0);
    chk("rst_cout1", {15'd0, cout1}, 16'd0);
    chk("rst_sum8", {8'd0, sum8}, 16'd0);
    chk("rst_cout8", {15'd0, cout8}, 16'd0);
    step();
    chk("rst_edge_sum8", {8'd0, sum8}, 16'd0);
    chk("rst_edge_cout8", {15'd0, cout8}, 16'd0);
`ifdef FA_OVERFLOW_EN
    chk("rst_ovf8", {15'd0, ovf8}, 16'd0);
`endif
    #4;
    rst = 1'b0;

    // WIDTH=1 truth table, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      drive1(i[2:0]);
      step();
      chk($sformatf("tt_%0d", i), {14'd0, cout1, sum1}, {14'd0, tt[i]});
    end

    // WIDTH=8 boundaries and carry propagation across the full width
    drive8(8'h00, 8'h00, 1'b0); exp_q.push_back(10'b0_0_0000_0000); step(); chk8("zeros");
    drive8(8'hFF, 8'h00, 1'b1); exp_q.push_back(10'b0_1_0000_0000); step(); chk8("ff_00_c1");
    drive8(8'hFF, 8'hFF, 1'b1); exp_q.push_back(10'b0_1_1111_1111); step(); chk8("ff_ff_c1");
    drive8(8'h7F, 8'h01, 1'b0); exp_q.push_back(10'b1_0_1000_0000); step(); chk8("7f_01");
    drive8(8'h80, 8'hFF, 1'b0); exp_q.push_back(10'b1_1_0111_1111); step(); chk8("80_ff");
    drive8(8'h10, 8'h20, 1'b0); exp_q.push_back(10'b0_0_0011_0000); step(); chk8("10_20");

    // Asynchronous reset between edges, then recovery on the next edge
    drive1(3'b111);
    step();
    chk("pre_rst", {14'd0, cout1, sum1}, 16'h0003);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst1", {14'd0, cout1, sum1}, 16'h0000);
    chk("async_rst8", {7'd0, cout8, sum8}, 16'h0000);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst", {14'd0, cout1, sum1}, 16'h0003);

    // Back-to-back random stream: every cycle checks the previous cycle's inputs
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      drive8(ra, rb, rc);
      exp_q.push_back(ref8(ra, rb, rc));
      step();
      chk8($sformatf("stream_%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_full_adder
